// File: rtl/sram_arb_pkg.sv
// Purpose : shared types and constants for the SRAM port arbiter.
// Latency : n/a (declarations only).
// Backpres: n/a.
package sram_arb_pkg;

    // Largest supported requester count; sizes the generic port index type.
    localparam int MAX_PORTS = 8;

    // The macro returns read data one cycle after the access cycle.
    localparam int MEM_READ_LATENCY = 1;

    // Width of an encoded port index; at least one bit so a 2-port build works.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Purpose : round-robin priority picker; first asserted req at or after ptr, with wrap.
// Latency : purely combinational.
// Backpres: none; caller owns the pointer register and decides when it advances.
// Ports   : req (per-port request), ptr (start index) -> gnt (one-hot), idx (encoded), any.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam int          PW1 = PW + 1;
    localparam logic [PW:0] NV  = PW1'(N);

    // One extra bit so ptr+offset cannot overflow before the wrap subtraction.
    logic [PW:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr} + PW1'(off);
            if (cand >= NV) cand = cand - NV;
            if (!any && req[cand[PW-1:0]]) begin
                any                = 1'b1;
                gnt[cand[PW-1:0]] = 1'b1;
                idx                = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Purpose : shares one single-port byte-maskable SRAM macro among NUM_PORTS requesters.
// Latency : grant same cycle as req; rvalid/rdata one cycle after grant.
// Backpres: a requester holds its request until gnt; one access per cycle total.
// Ports   : req_i/we_i/be_i/addr_i/wdata_i (packed per port) -> gnt_o, rvalid_o, rdata_o;
//           mem_csn_o/mem_wen_o/mem_ben_o (active-low), mem_a_o, mem_d_o -> macro; mem_q_i <- macro.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int NUM_PORTS  = 3,
    parameter  int ADDR_WIDTH = 12,
    parameter  int DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_PORTS-1:0]             req_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]    be_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_csn_o,
    output logic                             mem_wen_o,
    output logic [ADDR_WIDTH-1:0]            mem_a_o,
    output logic [DATA_WIDTH-1:0]            mem_d_o,
    output logic [BE_WIDTH-1:0]              mem_ben_o,
    input  logic [DATA_WIDTH-1:0]            mem_q_i
);

    localparam int PW = ptr_width(NUM_PORTS);

    logic [ADDR_WIDTH-1:0] port_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_d [NUM_PORTS];
    logic [BE_WIDTH-1:0]   port_be[NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
        assign port_a[k]  = addr_i [k*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_d[k]  = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign port_be[k] = be_i   [k*BE_WIDTH   +: BE_WIDTH];
    end

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         ptr_next;
    logic [NUM_PORTS-1:0]  arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  grant_vld;
    logic                  wr_sel;
    logic [NUM_PORTS-1:0]  gnt_q;
    logic                  rd_q;
    logic [DATA_WIDTH-1:0] rdata_hold;
    logic [ADDR_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] d_hold;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_rr_arbiter (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Grants are suppressed while reset is held so the macro sees no access.
    assign grant_vld = arb_any & ~RST;
    assign gnt_o     = grant_vld ? arb_gnt : '0;
    assign wr_sel    = we_i[arb_idx];
    assign ptr_next  = (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + PW'(1);

    always_comb begin
        mem_csn_o = 1'b1;
        mem_wen_o = 1'b1;
        mem_ben_o = '1;
        mem_a_o   = a_hold;
        mem_d_o   = d_hold;
        if (grant_vld) begin
            mem_csn_o = 1'b0;
            mem_wen_o = ~wr_sel;
            mem_a_o   = port_a[arb_idx];
            mem_d_o   = port_d[arb_idx];
            // Reads never assert byte strobes; a be=0 write leaves memory untouched.
            if (wr_sel) mem_ben_o = ~port_be[arb_idx];
        end
    end

    // rd_q marks that the response in flight is a read, so mem_q_i is meaningful.
    assign rvalid_o = gnt_q;
    assign rdata_o  = rd_q ? mem_q_i : rdata_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr     <= '0;
            gnt_q      <= '0;
            rd_q       <= 1'b0;
            rdata_hold <= '0;
            a_hold     <= '0;
            d_hold     <= '0;
        end else begin
            gnt_q <= gnt_o;
            rd_q  <= grant_vld & ~wr_sel;
            if (rd_q) rdata_hold <= mem_q_i;
            if (grant_vld) begin
                rr_ptr <= ptr_next;
                a_hold <= mem_a_o;
                d_hold <= mem_d_o;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Purpose : self-checking bench for sram_port_arbiter with an SRAM macro model and a reference model.
// Latency : checks combinational outputs mid-cycle and responses one cycle after grant.
// Backpres: stimulus requesters hold or drop requests freely; reference model tracks outcomes.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    req_i, we_i;
    logic [N*BW-1:0] be_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o, mem_d_o, mem_q_i;
    logic            mem_csn_o, mem_wen_o;
    logic [AW-1:0]   mem_a_o;
    logic [BW-1:0]   mem_ben_o;

    always #5 CLK = ~CLK;

    sram_port_arbiter #(
        .NUM_PORTS  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_i     (req_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .mem_csn_o (mem_csn_o),
        .mem_wen_o (mem_wen_o),
        .mem_a_o   (mem_a_o),
        .mem_d_o   (mem_d_o),
        .mem_ben_o (mem_ben_o),
        .mem_q_i   (mem_q_i)
    );

    // Behavioural SRAM macro: active-low controls, one-cycle read latency.
    logic [DW-1:0] macro_mem [0:(1<<AW)-1];
    logic [DW-1:0] mwr;
    always @(posedge CLK) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) begin
                mwr = macro_mem[mem_a_o];
                for (int b = 0; b < BW; b++)
                    if (!mem_ben_o[b]) mwr[8*b +: 8] = mem_d_o[8*b +: 8];
                macro_mem[mem_a_o] <= mwr;
            end else begin
                mem_q_i <= macro_mem[mem_a_o];
            end
        end
    end

    // Reference model state: what requesters should observe.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            ptr;
    logic [N-1:0]  exp_rv;
    bit            rd_pend;
    logic [DW-1:0] rd_val, hold;
    logic [AW-1:0] last_a;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            int c;
            c = (p + off) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_port(input int k, input bit r, input bit w, input logic [BW-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[k]            = r;
        we_i[k]             = w;
        be_i[k*BW +: BW]    = be;
        addr_i[k*AW +: AW]  = a;
        wdata_i[k*DW +: DW] = d;
    endtask

    task automatic clear_ports();
        req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        macro_mem[a] = v;
        ref_mem[a]   = v;
    endtask

    task automatic model_reset();
        ptr = 0; exp_rv = '0; rd_pend = 0; rd_val = '0; hold = '0; last_a = '0;
    endtask

    // Called at posedge+1 with inputs already set; checks the cycle, then advances the model.
    task automatic tick(input string tag);
        int            g;
        logic [DW-1:0] exp_rdata;
        logic [BW-1:0] pbe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        bit            pw;
        #3;
        g         = pick(req_i, ptr);
        exp_rdata = rd_pend ? rd_val : hold;
        chk({tag, "_gnt"},    gnt_o,     (g >= 0) ? (1 << g) : 0);
        chk({tag, "_rvalid"}, rvalid_o,  exp_rv);
        chk({tag, "_csn"},    mem_csn_o, (g < 0) ? 1 : 0);
        chk({tag, "_rdata"},  rdata_o,   exp_rdata);
        if (g >= 0) begin
            pw  = we_i[g];
            pbe = be_i[g*BW +: BW];
            pa  = addr_i[g*AW +: AW];
            pd  = wdata_i[g*DW +: DW];
            last_a = pa;
            chk({tag, "_wen"}, mem_wen_o, pw ? 0 : 1);
            chk({tag, "_ben"}, mem_ben_o, pw ? {60'd0, ~pbe} : 64'hF);
            if (pw) chk({tag, "_d"}, mem_d_o, pd);
        end else begin
            pw = 0; pbe = '0; pa = '0; pd = '0;
            chk({tag, "_wen"}, mem_wen_o, 1);
            chk({tag, "_ben"}, mem_ben_o, 64'hF);
        end
        chk({tag, "_a"}, mem_a_o, last_a);
        if (rd_pend) hold = rd_val;
        rd_pend = 0;
        exp_rv  = '0;
        if (g >= 0) begin
            exp_rv = N'(1 << g);
            if (pw) begin
                for (int b = 0; b < BW; b++)
                    if (pbe[b]) ref_mem[pa][8*b +: 8] = pd[8*b +: 8];
            end else begin
                rd_pend = 1;
                rd_val  = ref_mem[pa];
            end
            ptr = (g + 1) % N;
        end
        @(posedge CLK);
        #1;
    endtask

    // Reset with every port requesting to show grants and memory controls are gated.
    task automatic do_reset();
        RST = 1'b1;
        clear_ports();
        req_i = '1;
        @(posedge CLK);
        #1;
        chk("rst_gnt",    gnt_o,     0);
        chk("rst_csn",    mem_csn_o, 1);
        chk("rst_wen",    mem_wen_o, 1);
        chk("rst_ben",    mem_ben_o, 64'hF);
        chk("rst_rvalid", rvalid_o,  0);
        chk("rst_rdata",  rdata_o,   0);
        RST = 1'b0;
        clear_ports();
        model_reset();
    endtask

    initial begin
        RST = 1'b1;
        mem_q_i = '0;
        clear_ports();
        for (int i = 0; i < (1 << AW); i++) begin
            macro_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        model_reset();
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) tick("idle");

        // Masked write into preloaded word, then read back.
        preload(12'h010, 32'h11223344);
        set_port(0, 1, 1, 4'b0011, 12'h010, 32'hDEADBEEF);
        #3;
        chk("wr_ben_const", mem_ben_o, 4'b1100);
        chk("wr_wen_const", mem_wen_o, 0);
        tick("wr");
        set_port(0, 1, 0, 4'b0000, 12'h010, 32'h0);
        tick("rd");
        chk("rd_rvalid_const", rvalid_o, 3'b001);
        chk("rd_rdata_const",  rdata_o,  32'h1122BEEF);
        clear_ports();
        tick("rd_done");

        // All ports requesting continuously from reset.
        do_reset();
        for (int k = 0; k < N; k++) set_port(k, 1, 0, 4'h0, AW'(12'h100 + k), 32'h0);
        for (int i = 0; i < 9; i++) begin
            #3;
            chk("rr_order", gnt_o, 1 << (i % 3));
            tick("rr");
        end

        // Pointer is back at 0: lone port 2, then ports 0 and 2.
        clear_ports();
        set_port(2, 1, 0, 4'h0, 12'h005, 32'h0);
        #3;
        chk("lone_p2", gnt_o, 3'b100);
        tick("lone");
        set_port(0, 1, 0, 4'h0, 12'h006, 32'h0);
        #3;
        chk("wrap_p0", gnt_o, 3'b001);
        tick("wrap");
        clear_ports();
        tick("wrap_done");

        // Read data persists across a later write and idle cycles.
        preload(12'h020, 32'hCAFEF00D);
        set_port(1, 1, 0, 4'h0, 12'h020, 32'h0);
        tick("hold_rd");
        clear_ports();
        set_port(0, 1, 1, 4'hF, 12'h020, 32'h12345678);
        chk("hold_pass", rdata_o, 32'hCAFEF00D);
        tick("hold_wr");
        clear_ports();
        for (int i = 0; i < 3; i++) begin
            chk("hold_keep", rdata_o, 32'hCAFEF00D);
            tick("hold_idle");
        end

        // Reset asserted after a grant but before the edge.
        set_port(1, 1, 0, 4'h0, 12'h020, 32'h0);
        #3;
        chk("mid_gnt", gnt_o, 1 << pick(req_i, ptr));
        RST = 1'b1;
        #1;
        chk("mid_gnt_gated", gnt_o,     0);
        chk("mid_csn_gated", mem_csn_o, 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clear_ports();
        model_reset();
        tick("mid_after");
        set_port(1, 1, 0, 4'h0, 12'h011, 32'h0);
        set_port(2, 1, 0, 4'h0, 12'h012, 32'h0);
        #3;
        chk("mid_first", gnt_o, 3'b010);
        tick("mid_first");
        clear_ports();
        tick("mid_done");

        // Random traffic on a small address window, including be=0 writes.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++)
                set_port(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         BW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom);
            tick("rnd");
        end
        clear_ports();
        tick("rnd_done");
        tick("rnd_done");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule
